ifetch_queue: RTL

Instruction-fetch front end for the pipelined MIPS core, sitting between a variable-latency instruction memory and the IF/ID pipeline register. It owns the fetch PC, issues one word-aligned read at a time over a req/ack handshake, and buffers returned words with their PC+4 in a DEPTH-entry FIFO. The head entry is presented to IF/ID with valid/ready. A branch or jump redirect from EX flushes the queue and restarts fetch at the target address.

---
 rtl/ifetch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one word read at a time
// over req/ack, and buffers returned words with their PC+4 for the IF/ID stage.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_incr,
    input  logic        instr_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        instr_mem_q [DEPTH];
    logic [31:0]        pcinc_mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic [31:0]        redirect_word;
    logic               unused_redirect_bits;

    assign redirect_word        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push        = mem_ack & (state_q == S_REQ) & ~redirect;

    assign mem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign mem_addr = addr_q;
    assign instr    = instr_mem_q[rd_ptr_q];
    assign pc_incr  = pcinc_mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        // A redirect wins over push/pop: the whole queue is dropped.
        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_word;
        end

        case (state_q)
            S_IDLE: begin
                if (!redirect && (count_d < DEPTH_C)) begin
                    state_d = S_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    // An unacked request cannot be withdrawn, so wait it out in DRAIN.
                    state_d = mem_ack ? S_IDLE : S_DRAIN;
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (count_d < DEPTH_C) begin
                        addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // The stored PC+4 is taken from the request address, which equals fetch_pc in REQ.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    instr_mem_q[gi] <= '0;
                    pcinc_mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    instr_mem_q[gi] <= mem_rdata;
                    pcinc_mem_q[gi] <= addr_q + 32'd4;
                end
            end
        end
    endgenerate

endmodule
